bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_if.sv | 21 ++
 rtl/bus_timer.sv | 148 ++++++++++++++
 tb/tb_bus_timer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_if.sv
// CPU-side memory bus as seen by the bus timer.
// The CPU drives address, data and strobes; the timer answers with read data, hit and irq.
interface bus_timer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        mem_rd;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  modport master (
    output mem_addr, mem_data, mem_we, mem_rd,
    input  rdata, hit, irq
  );

  modport slave (
    input  mem_addr, mem_data, mem_we, mem_rd,
    output rdata, hit, irq
  );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and a level interrupt.
// Register window (word offsets): 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic         clk,
  input  logic         rst,
  bus_timer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic        r_en;
  logic        r_ie;
  logic        r_auto;
  logic [7:0]  r_presc;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_pend;
  logic [7:0]  r_pcnt;

  state_t      w_state_next;
  logic        w_en_next;
  logic        w_ie_next;
  logic        w_auto_next;
  logic [7:0]  w_presc_next;
  logic [31:0] w_load_next;
  logic [31:0] w_count_next;
  logic        w_pend_next;
  logic [7:0]  w_pcnt_next;
  logic        w_pend_set;
  logic        w_pend_clr;
  logic        w_hit;
  logic        w_wr;
  logic [1:0]  w_sel;

  assign w_hit = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel = bus.mem_addr[3:2];
  assign w_wr  = w_hit & bus.mem_we;

  assign bus.hit = w_hit;
  assign bus.irq = r_pend & r_ie;

  // Combinational register read; zero unless this is a read of our window.
  always_comb begin
    bus.rdata = 32'h0;
    if (w_hit && bus.mem_rd) begin
      case (w_sel)
        2'd0:    bus.rdata = {16'h0, r_presc, 5'h0, r_auto, r_ie, r_en};
        2'd1:    bus.rdata = r_load;
        2'd2:    bus.rdata = r_count;
        default: bus.rdata = {30'h0, (r_state == S_RUN), r_pend};
      endcase
    end
  end

  // Next-state logic: counting first, then bus writes layered on top so they win.
  always_comb begin
    w_state_next = r_state;
    w_en_next    = r_en;
    w_ie_next    = r_ie;
    w_auto_next  = r_auto;
    w_presc_next = r_presc;
    w_load_next  = r_load;
    w_count_next = r_count;
    w_pcnt_next  = r_pcnt;
    w_pend_set   = 1'b0;
    w_pend_clr   = 1'b0;

    case (r_state)
      S_RUN: begin
        if (r_pcnt == r_presc) begin
          w_pcnt_next = 8'd0;
          if (r_count != 32'd0) begin
            w_count_next = r_count - 32'd1;
          end else begin
            w_pend_set = 1'b1;
            if (r_auto) begin
              w_count_next = r_load;
            end else begin
              w_en_next    = 1'b0;
              w_state_next = S_DONE;
            end
          end
        end else begin
          w_pcnt_next = r_pcnt + 8'd1;
        end
      end
      default: ;
    endcase

    if (w_wr) begin
      case (w_sel)
        2'd0: begin
          w_ie_next    = bus.mem_data[1];
          w_auto_next  = bus.mem_data[2];
          w_presc_next = bus.mem_data[15:8];
          if (!bus.mem_data[0]) begin
            // Disabling freezes the timer exactly where it was, tick included.
            w_en_next    = 1'b0;
            w_state_next = S_IDLE;
            w_count_next = r_count;
            w_pcnt_next  = r_pcnt;
            w_pend_set   = 1'b0;
          end else if (!r_en) begin
            w_en_next    = 1'b1;
            w_count_next = r_load;
            w_pcnt_next  = 8'd0;
            w_state_next = S_RUN;
          end
        end
        2'd1: w_load_next  = bus.mem_data;
        2'd2: w_count_next = bus.mem_data;
        default: w_pend_clr = bus.mem_data[0];
      endcase
    end

    // A same-cycle expiry beats the software clear.
    w_pend_next = (r_pend & ~w_pend_clr) | w_pend_set;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_auto  <= 1'b0;
      r_presc <= 8'd0;
      r_load  <= 32'd0;
      r_count <= 32'd0;
      r_pend  <= 1'b0;
      r_pcnt  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_en    <= w_en_next;
      r_ie    <= w_ie_next;
      r_auto  <= w_auto_next;
      r_presc <= w_presc_next;
      r_load  <= w_load_next;
      r_count <= w_count_next;
      r_pend  <= w_pend_next;
      r_pcnt  <= w_pcnt_next;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: directed bus transactions, expected read responses queued
// by the stimulus and checked by an independent monitor when a read is on the bus.
module tb_bus_timer;
  localparam logic [31:0] B = 32'hFFFF_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
  } exp_t;

  logic clk;
  logic rst;
  bus_timer_if bus();

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp;
  int    n_fail;

  bus_timer #(.BASE_ADDR(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a read is presented during the cycle; sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_read: rdata=%h with no expectation queued", bus.rdata);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (bus.rdata !== e.rdata || bus.hit !== e.hit || bus.irq !== e.irq) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h hit=%b irq=%b, want rdata=%h hit=%b irq=%b",
                   nm, bus.rdata, bus.hit, bus.irq, e.rdata, e.hit, e.irq);
        end else begin
          $display("ok   %s: rdata=%h hit=%b irq=%b", nm, bus.rdata, bus.hit, bus.irq);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.mem_addr = addr;
    bus.mem_data = data;
    bus.mem_we   = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_we   = 1'b0;
    bus.mem_data = 32'h0;
    $display("wr   addr=%h data=%h", addr, data);
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] rd,
                          input logic h, input logic irq, input string nm);
    exp_t e;
    e.rdata = rd;
    e.hit   = h;
    e.irq   = irq;
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus.mem_addr = addr;
    bus.mem_rd   = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_rd   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("rst  one-cycle reset pulse");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.mem_addr = 32'h0;
    bus.mem_data = 32'h0;
    bus.mem_we   = 1'b0;
    bus.mem_rd   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    bus_read(B + 32'h0, 32'h0, 1'b1, 1'b0, "rst_ctrl");
    bus_read(B + 32'h4, 32'h0, 1'b1, 1'b0, "rst_load");
    bus_read(B + 32'h8, 32'h0, 1'b1, 1'b0, "rst_count");
    bus_read(B + 32'hC, 32'h0, 1'b1, 1'b0, "rst_status");

    // One-shot: LOAD=3, EN|IE, PRESC=0 -> PEND 4 cycles after the CTRL write edge
    bus_write(B + 32'h4, 32'h3);
    bus_write(B + 32'h0, 32'h3);
    bus_read(B + 32'hC, 32'h2, 1'b1, 1'b0, "os_status_e0");
    bus_read(B + 32'h8, 32'h2, 1'b1, 1'b0, "os_count_e1");
    bus_read(B + 32'h9, 32'h1, 1'b1, 1'b0, "os_count_e2_lowbits");
    bus_read(B + 32'hC, 32'h2, 1'b1, 1'b0, "os_status_e3");
    bus_read(B + 32'hC, 32'h1, 1'b1, 1'b1, "os_status_e4_done");
    bus_read(B + 32'h0, 32'h2, 1'b1, 1'b1, "os_ctrl_en_cleared");
    bus_write(B + 32'hC, 32'h1);
    bus_read(B + 32'hC, 32'h0, 1'b1, 1'b0, "os_w1c");

    // Auto-reload: LOAD=1, PRESC=2 -> expiries every 6 cycles (E6, E12, E18)
    bus_write(B + 32'h4, 32'h1);
    bus_write(B + 32'h0, 32'h0000_0207);
    idle(5);
    bus_read(B + 32'hC, 32'h2, 1'b1, 1'b0, "ar_before_e6");
    bus_read(B + 32'hC, 32'h3, 1'b1, 1'b1, "ar_at_e6");
    bus_write(B + 32'hC, 32'h1);
    bus_read(B + 32'hC, 32'h2, 1'b1, 1'b0, "ar_cleared");
    idle(2);
    bus_read(B + 32'hC, 32'h2, 1'b1, 1'b0, "ar_before_e12");
    bus_read(B + 32'hC, 32'h3, 1'b1, 1'b1, "ar_at_e12");
    // Clear, then a second clear lands exactly on the E18 expiry: set wins
    bus_write(B + 32'hC, 32'h1);
    idle(3);
    bus_write(B + 32'hC, 32'h1);
    bus_read(B + 32'hC, 32'h3, 1'b1, 1'b1, "ar_set_beats_clear");
    // Dropping IE masks irq but PEND stays
    bus_write(B + 32'h0, 32'h0000_0205);
    bus_read(B + 32'hC, 32'h3, 1'b1, 1'b0, "mask_ie");
    bus_write(B + 32'h0, 32'h0);
    bus_read(B + 32'hC, 32'h1, 1'b1, 1'b0, "disable_idle");

    // Live COUNT read and out-of-window access
    bus_write(B + 32'hC, 32'h1);
    bus_write(B + 32'h4, 32'h10);
    bus_write(B + 32'h0, 32'h1);
    bus_read(B + 32'h8, 32'h10, 1'b1, 1'b0, "live_count_e0");
    bus_read(B + 32'h8, 32'hF, 1'b1, 1'b0, "live_count_e1");
    bus_read(B + 32'h10, 32'h0, 1'b0, 1'b0, "miss_read");
    bus_write(B + 32'h10, 32'h0);
    bus_read(B + 32'h8, 32'hC, 1'b1, 1'b0, "miss_write_ignored");
    bus_read(B + 32'h0, 32'h1, 1'b1, 1'b0, "miss_ctrl_intact");
    bus_write(B + 32'h0, 32'h0);

    // COUNT write on a tick cycle overrides the decrement
    bus_write(B + 32'h4, 32'h3);
    bus_write(B + 32'h0, 32'h1);
    idle(1);
    bus_write(B + 32'h8, 32'h5);
    bus_read(B + 32'h8, 32'h5, 1'b1, 1'b0, "cw_override");
    idle(4);
    bus_read(B + 32'hC, 32'h2, 1'b1, 1'b0, "cw_before_expiry");
    bus_read(B + 32'hC, 32'h1, 1'b1, 1'b0, "cw_expiry_6_ticks");

    // Reset mid-count
    bus_write(B + 32'h4, 32'h100);
    bus_write(B + 32'h0, 32'h3);
    bus_read(B + 32'hC, 32'h3, 1'b1, 1'b1, "pre_reset_status");
    idle(2);
    pulse_reset();
    bus_read(B + 32'h0, 32'h0, 1'b1, 1'b0, "mr_ctrl");
    bus_read(B + 32'h4, 32'h0, 1'b1, 1'b0, "mr_load");
    bus_read(B + 32'h8, 32'h0, 1'b1, 1'b0, "mr_count");
    bus_read(B + 32'hC, 32'h0, 1'b1, 1'b0, "mr_status");

    idle(2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
